psum_writeback: RTL and testbench

Drain stage directly downstream of the `sfu` accumulator. It captures the packed `input_ch`-lane partial-sum vector when `load` is strobed, and applies per-lane ReLU, arithmetic right-shift and unsigned saturation. It then writes the lanes one per transfer into the output SRAM, with ready-based backpressure. A `done` pulse is issued after the last lane; loads that arrive while the block is busy are dropped and flagged.

---
 rtl/psum_writeback.sv | 120 ++++++++++++
 tb/tb_psum_writeback.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback.sv
// Drain stage behind the sfu accumulator: captures a packed psum vector, then writes
// each lane to SRAM after ReLU, arithmetic shift and unsigned saturation.
module psum_writeback #(
  parameter int psum_bw  = 16,
  parameter int input_ch = 16,
  parameter int out_bw   = 8,
  parameter int addr_bw  = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [psum_bw*input_ch-1:0]  psums_in,
  input  logic                         load,
  input  logic [addr_bw-1:0]           base_addr,
  input  logic [3:0]                   shamt,
  input  logic                         relu_en,
  input  logic                         mem_ready,
  output logic                         mem_wr_en,
  output logic [addr_bw-1:0]           mem_addr,
  output logic [out_bw-1:0]            mem_data,
  output logic                         busy,
  output logic                         done,
  output logic                         load_drop
);

  localparam int lane_bw = (input_ch > 1) ? $clog2(input_ch) : 1;
  localparam logic [lane_bw-1:0] last_lane = lane_bw'(input_ch - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state, next_state;
  logic [lane_bw-1:0]   lane;
  logic [psum_bw-1:0]   lane_buf [input_ch];
  logic [addr_bw-1:0]   base_q;
  logic [3:0]           shamt_q;
  logic                 relu_q;
  logic                 accept, xfer, last_xfer;

  // ReLU, then arithmetic shift, then clamp into [0, 2^out_bw-1]; assumes psum_bw > out_bw.
  function automatic logic [out_bw-1:0] lane_fn(input logic [psum_bw-1:0] x,
                                                input logic [3:0] sh,
                                                input logic relu);
    logic signed [psum_bw-1:0] y;
    if (relu && x[psum_bw-1])
      y = '0;
    else
      y = $signed(x) >>> sh;
    if (y[psum_bw-1])
      return '0;
    else if (|y[psum_bw-1:out_bw])
      return '1;
    else
      return y[out_bw-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept     = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          xfer = 1'b1;
          if (lane == last_lane) begin
            last_xfer  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane      <= '0;
      base_q    <= '0;
      shamt_q   <= '0;
      relu_q    <= 1'b0;
      done      <= 1'b0;
      load_drop <= 1'b0;
      for (int i = 0; i < input_ch; i++)
        lane_buf[i] <= '0;
    end else begin
      done <= last_xfer;
      if (load && state == DRAIN)
        load_drop <= 1'b1;
      if (accept) begin
        for (int i = 0; i < input_ch; i++)
          lane_buf[i] <= psums_in[psum_bw*i +: psum_bw];
        base_q  <= base_addr;
        shamt_q <= shamt;
        relu_q  <= relu_en;
        lane    <= '0;
      end else if (xfer) begin
        lane <= last_xfer ? '0 : lane + 1'b1;
      end
    end
  end

  // Outputs are forced to zero outside DRAIN so idle values match the reset values.
  assign busy      = (state == DRAIN);
  assign mem_wr_en = busy;
  assign mem_addr  = busy ? base_q + addr_bw'(lane) : '0;
  assign mem_data  = busy ? lane_fn(lane_buf[lane], shamt_q, relu_q) : '0;

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: table of per-lane function vectors plus
// directed sequences for backpressure, dropped loads, address wrap and mid-drain reset.
module tb_psum_writeback;

  logic         clk;
  logic         reset;
  logic [255:0] psums_in;
  logic         load;
  logic [10:0]  base_addr;
  logic [3:0]   shamt;
  logic         relu_en;
  logic         mem_ready;
  logic         mem_wr_en;
  logic [10:0]  mem_addr;
  logic [7:0]   mem_data;
  logic         busy;
  logic         done;
  logic         load_drop;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  sh;
    logic        relu;
    logic [10:0] base;
    logic [7:0]  exp;
  } vec_t;

  vec_t        tbl [12];
  logic [7:0]  exp_data [16];
  logic [255:0] vec;
  int          cyc;

  psum_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .psums_in  (psums_in),
    .load      (load),
    .base_addr (base_addr),
    .shamt     (shamt),
    .relu_en   (relu_en),
    .mem_ready (mem_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .load_drop (load_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a load at the current falling edge, then scramble the latched controls.
  task automatic start_load(input logic [255:0] v, input logic [10:0] b,
                            input logic [3:0] sh, input logic relu);
    psums_in  = v;
    base_addr = b;
    shamt     = sh;
    relu_en   = relu;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    base_addr = ~b;
    shamt     = ~sh;
    relu_en   = ~relu;
  endtask

  // Walk all lanes, checking each presented word; stops in the done cycle.
  task automatic drain(input logic [10:0] base, input int stall_lane, input int stall_n,
                       input int drop_lane, output int cycles);
    int          lane = 0;
    int          stalls = 0;
    bit          dropped = 0;
    logic [10:0] ea;
    cycles = 0;
    while (lane < 16 && cycles < 200) begin
      ea = base + 11'(lane);
      check("wr_en", mem_wr_en, 1);
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("addr", mem_addr, ea);
      check("data", mem_data, exp_data[lane]);
      load = 1'b0;
      if (lane == drop_lane && !dropped) begin
        load     = 1'b1;
        psums_in = ~psums_in;
        dropped  = 1;
      end
      if (lane == stall_lane && stalls < stall_n) begin
        mem_ready = 1'b0;
        stalls++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      cycles++;
      if (mem_ready) lane++;
    end
    load      = 1'b0;
    mem_ready = 1'b1;
    if (lane < 16) check("drain_timeout", lane, 16);
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("wr_en_after", mem_wr_en, 0);
    check("drain_cycles", cycles, 16 + stall_n);
  endtask

  initial begin
    tbl[0]  = '{16'hFFFB, 4'd1,  1'b1, 11'h000, 8'd0};
    tbl[1]  = '{16'h7FFF, 4'd1,  1'b1, 11'h010, 8'd255};
    tbl[2]  = '{16'h0300, 4'd1,  1'b1, 11'h123, 8'd255};
    tbl[3]  = '{16'h0025, 4'd1,  1'b1, 11'h7FA, 8'd18};
    tbl[4]  = '{16'hFFFB, 4'd1,  1'b0, 11'h040, 8'd0};
    tbl[5]  = '{16'h8000, 4'd15, 1'b0, 11'h7FF, 8'd0};
    tbl[6]  = '{16'h00FF, 4'd0,  1'b1, 11'h200, 8'd255};
    tbl[7]  = '{16'h0100, 4'd0,  1'b1, 11'h300, 8'd255};
    tbl[8]  = '{16'h01FE, 4'd1,  1'b0, 11'h055, 8'd255};
    tbl[9]  = '{16'h1234, 4'd8,  1'b0, 11'h400, 8'd18};
    tbl[10] = '{16'h00AB, 4'd0,  1'b0, 11'h600, 8'd171};
    tbl[11] = '{16'hFFFF, 4'd0,  1'b0, 11'h0F0, 8'd0};

    reset     = 1'b1;
    psums_in  = '0;
    load      = 1'b0;
    base_addr = '0;
    shamt     = '0;
    relu_en   = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_drop", load_drop, 0);
    reset = 1'b0;
    psums_in = {16{16'h5555}};
    @(negedge clk);
    check("idle_no_load", busy, 0);

    $display("[TB] plain drain");
    for (int i = 0; i < 16; i++) begin
      vec[16*i +: 16] = 16'(10 * i);
      exp_data[i]     = 8'(10 * i);
    end
    start_load(vec, 11'h100, 4'd0, 1'b1);
    drain(11'h100, -1, 0, -1, cyc);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);

    $display("[TB] lane function table");
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) exp_data[i] = tbl[t].exp;
      start_load({16{tbl[t].x}}, tbl[t].base, tbl[t].sh, tbl[t].relu);
      drain(tbl[t].base, -1, 0, -1, cyc);
      @(negedge clk);
      check("tbl_done_low", done, 0);
    end

    $display("[TB] mixed vector with 3-cycle stall on lane 2");
    vec = {4{16'h0025, 16'h0300, 16'h7FFF, 16'hFFFB}};
    for (int i = 0; i < 16; i += 4) begin
      exp_data[i]     = 8'd0;
      exp_data[i + 1] = 8'd255;
      exp_data[i + 2] = 8'd255;
      exp_data[i + 3] = 8'd18;
    end
    start_load(vec, 11'h080, 4'd1, 1'b1);
    drain(11'h080, 2, 3, -1, cyc);
    @(negedge clk);
    start_load(vec, 11'h090, 4'd1, 1'b0);
    drain(11'h090, -1, 0, -1, cyc);
    @(negedge clk);

    $display("[TB] dropped load and back-to-back load");
    for (int i = 0; i < 16; i++) begin
      vec[16*i +: 16] = 16'(10 * i);
      exp_data[i]     = 8'(10 * i);
    end
    start_load(vec, 11'h100, 4'd0, 1'b1);
    drain(11'h100, -1, 0, 5, cyc);
    check("load_drop_set", load_drop, 1);
    for (int i = 0; i < 16; i++) exp_data[i] = 8'd16;
    start_load({16{16'h0040}}, 11'h500, 4'd2, 1'b0);
    drain(11'h500, -1, 0, -1, cyc);
    check("load_drop_sticky", load_drop, 1);
    @(negedge clk);

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 16; i++) vec[16*i +: 16] = 16'(10 * i);
    start_load(vec, 11'h020, 4'd0, 1'b1);
    repeat (7) @(negedge clk);
    check("pre_rst_addr", mem_addr, 11'h027);
    check("pre_rst_data", mem_data, 70);
    #1 reset = 1'b1;
    #1;
    check("async_wr_en", mem_wr_en, 0);
    check("async_busy", busy, 0);
    check("async_load_drop", load_drop, 0);
    check("async_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
    end
    for (int i = 0; i < 16; i++) exp_data[i] = 8'd5;
    start_load({16{16'h0005}}, 11'h300, 4'd0, 1'b1);
    drain(11'h300, -1, 0, -1, cyc);
    @(negedge clk);
    check("final_done_low", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
